dmem_core_arbiter: RTL and testbench
====================================

// Module: dmem_core_arbiter
// PURPOSE
//  N-core D-memory request arbiter feeding the shared atomic unit. Latches one
//  outstanding request per core, selects round-robin, issues one strobe downstream
//  with a stable core ID and payload, holds the grant until downstream done, and
//  routes done/data back. Grant is never switched mid AMO/LR/SC sequence.
// PARAMETERS
//  N     4   number of cores, 2..4 (core_id_o is 2 bits)
//  XLEN  32  address/data width
// PORTS
//  clk_i            in   1         clock
//  rst_ni           in   1         async active-low reset
//  core_strobe_i    in   N         per-core request pulse, 1 cycle
//  core_addr_i      in   N*XLEN    per-core address, slice k = core k
//  core_rw_i        in   N         1 = write
//  core_data_i      in   N*XLEN    per-core write data
//  core_is_amo_i    in   N         atomic request
//  core_amo_type_i  in   N*5       AMO funct5
//  core_done_o      out  N         per-core completion pulse
//  core_data_o      out  XLEN      read data, broadcast; valid with core_done_o[k]
//  amo_id_o         out  2         binary ID of granted core
//  amo_strobe_o     out  1         downstream request pulse
//  amo_addr_o/amo_data_o out XLEN  granted payload; amo_rw_o/amo_is_amo_o out 1
//  amo_type_o       out  5         granted AMO type
//  amo_done_i       in   1         downstream completion
//  amo_data_i       in   XLEN      downstream read data
// BEHAVIOUR
//  - Reset (async, rst_ni=0): pending=0, state=IDLE, rr_ptr=0, grant=0; all outputs
//    0. Reset mid-transaction abandons it; downstream shares the reset.
//  - Capture: core_strobe_i[k] & !pending[k] -> pending[k]<=1, latch addr/rw/data/
//    is_amo/type into req_k. Strobe while pending[k]=1 is ignored (protocol error).
//  - FSM IDLE: if |pending, winner = first pending index at or after rr_ptr
//    (wrapping mod N); grant<=winner; ->ISSUE. Else stay.
//  - ISSUE: amo_strobe_o=1 for exactly this cycle; ->WAIT.
//  - WAIT: on amo_done_i: core_done_o[grant]=1 (combinational, same cycle),
//    pending[grant]<=0, rr_ptr<=(grant+1) mod N, ->IDLE. Otherwise stay.
//  - amo_done_i outside WAIT is ignored; core_done_o is 0 for all non-granted cores.
//  - amo_addr/rw/data/is_amo/type_o and amo_id_o are registered from req_grant and
//    remain stable ISSUE through WAIT (atomic unit samples them across its
//    multi-cycle RMW). In IDLE they hold their last value.
//  - core_data_o = amo_data_i (pass-through; SC result is also returned here).
//  - Simultaneous done and new strobe on the granted core: set wins; new request
//    is pending and eligible at next IDLE.
//  - Latency: strobe at cycle 0 (state IDLE) -> amo_strobe_o at cycle 2.
//    Back-to-back turnaround is 2 cycles (WAIT->IDLE->ISSUE).
//  - Fairness: with all cores pending, service order k, k+1, ... wrap; no core waits
//    more than N-1 transactions.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds out N*32 grant_cnt_o (per-core completed
//  transactions) and out 32 contention_cnt_o (+1 each IDLE cycle with >=2 pending
//  bits, plus each ISSUE/WAIT cycle with any non-granted pending). Both are 0 on
//  reset and wrap at 2^32. Undefined: ports and logic absent; behaviour otherwise
//  identical.
// TESTING
//  - Single: core1 strobe addr=0x100 rd; done after 3 cyc, data=0xDEADBEEF ->
//    amo_id_o=1, amo_strobe at cycle 2, core_done_o=4'b0010, core_data_o=0xDEADBEEF.
//  - All 4 strobe same cycle, rr_ptr=0 -> grants 0,1,2,3; each strobe once; from
//    reset, the 4th done arrives in <= 4*(lat+2)+2 cycles.
//  - AMO hold: core2 AMOADD type=5'b00000 addr=0x40, done held off 10 cyc, core0
//    strobes meanwhile -> amo_id_o stays 2, payload stable; core0 served next.
//  - Re-request on done cycle: core3 strobes in same cycle as its done -> second
//    request issued; no lost/duplicate done.
//  - Reset mid-WAIT: rst_ni low 1 cyc -> all outputs 0 asynchronously, pending
//    cleared, no core_done_o after release.
//  - STATS_EN: 3 rounds of 2-core contention -> grant_cnt=3 each, contention_cnt>0.

Source files
------------

// File: rtl/dmem_core_arbiter.sv
// Round-robin arbiter: N cores share one atomic/D-memory unit, with the grant held
// from issue until the unit reports done. Optional statistics: DMEM_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | no transaction in flight; pick the next pending core round-robin
// ISSUE  | one-cycle downstream strobe; the payload registers are already loaded
// WAIT   | grant held until amo_done_i; completion is routed to the granted core
module dmem_core_arbiter #(
    parameter int N    = 4,
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      core_strobe_i,
    input  logic [N*XLEN-1:0] core_addr_i,
    input  logic [N-1:0]      core_rw_i,
    input  logic [N*XLEN-1:0] core_data_i,
    input  logic [N-1:0]      core_is_amo_i,
    input  logic [N*5-1:0]    core_amo_type_i,
    output logic [N-1:0]      core_done_o,
    output logic [XLEN-1:0]   core_data_o,
    output logic [1:0]        amo_id_o,
    output logic              amo_strobe_o,
    output logic [XLEN-1:0]   amo_addr_o,
    output logic [XLEN-1:0]   amo_data_o,
    output logic              amo_rw_o,
    output logic              amo_is_amo_o,
    output logic [4:0]        amo_type_o,
    input  logic              amo_done_i,
    input  logic [XLEN-1:0]   amo_data_i
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [N*32-1:0]   grant_cnt_o,
    output logic [31:0]       contention_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0]    pending, pending_nxt, clr, cap;
    logic [XLEN-1:0] req_addr [N];
    logic [XLEN-1:0] req_data [N];
    logic [4:0]      req_type [N];
    logic [N-1:0]    req_rw, req_is_amo;
    logic [1:0]      rr_ptr, grant, winner;
    logic [2:0]      idx;
    logic            found, any_pending, done_evt;

    assign any_pending = |pending;
    assign done_evt    = (state == S_WAIT) && amo_done_i;

    // A strobe landing on the cycle its own done clears the bit re-arms it (set wins).
    always_comb begin
        clr = '0;
        cap = '0;
        for (int k = 0; k < N; k++) begin
            clr[k] = done_evt && (grant == 2'(k));
            cap[k] = core_strobe_i[k] && (!pending[k] || clr[k]);
        end
        pending_nxt = (pending & ~clr) | cap;
    end

    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr} + 3'(i);
            if (idx >= 3'(N)) idx = idx - 3'(N);
            if (!found && pending[idx[1:0]]) begin
                found  = 1'b1;
                winner = idx[1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending    <= '0;
            req_rw     <= '0;
            req_is_amo <= '0;
            for (int k = 0; k < N; k++) begin
                req_addr[k] <= '0;
                req_data[k] <= '0;
                req_type[k] <= '0;
            end
        end else begin
            pending <= pending_nxt;
            for (int k = 0; k < N; k++) begin
                if (cap[k]) begin
                    req_addr[k]   <= core_addr_i[k*XLEN +: XLEN];
                    req_data[k]   <= core_data_i[k*XLEN +: XLEN];
                    req_type[k]   <= core_amo_type_i[k*5 +: 5];
                    req_rw[k]     <= core_rw_i[k];
                    req_is_amo[k] <= core_is_amo_i[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_pending) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (amo_done_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        amo_strobe_o = (state == S_ISSUE);
        core_done_o  = clr;
    end

    // Payload is loaded at arbitration so it is stable for the whole ISSUE..WAIT window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant        <= '0;
            rr_ptr       <= '0;
            amo_addr_o   <= '0;
            amo_data_o   <= '0;
            amo_rw_o     <= 1'b0;
            amo_is_amo_o <= 1'b0;
            amo_type_o   <= '0;
        end else begin
            if (state == S_IDLE && any_pending) begin
                grant        <= winner;
                amo_addr_o   <= req_addr[winner];
                amo_data_o   <= req_data[winner];
                amo_rw_o     <= req_rw[winner];
                amo_is_amo_o <= req_is_amo[winner];
                amo_type_o   <= req_type[winner];
            end
            if (done_evt) rr_ptr <= (grant == 2'(N-1)) ? 2'd0 : grant + 2'd1;
        end
    end

    assign amo_id_o    = grant;
    assign core_data_o = amo_data_i;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] grant_cnt [N];
    logic        contended;

    always_comb begin
        contended = 1'b0;
        if (state == S_IDLE) contended = ($countones(pending) >= 2);
        else                 contended = |(pending & ~(N'(1) << grant));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            contention_cnt_o <= '0;
            for (int k = 0; k < N; k++) grant_cnt[k] <= '0;
        end else begin
            if (contended) contention_cnt_o <= contention_cnt_o + 32'd1;
            for (int k = 0; k < N; k++)
                if (clr[k]) grant_cnt[k] <= grant_cnt[k] + 32'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) grant_cnt_o[k*32 +: 32] = grant_cnt[k];
    end
`endif

endmodule

// File: tb/tb_dmem_core_arbiter.sv
// Bench for dmem_core_arbiter: directed scenarios plus random traffic against a
// cycle-level transaction model of the round-robin/grant-hold rules.
module tb_dmem_core_arbiter;
    localparam int N = 4;
    localparam int XLEN = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      core_strobe_i;
    logic [N*XLEN-1:0] core_addr_i;
    logic [N-1:0]      core_rw_i;
    logic [N*XLEN-1:0] core_data_i;
    logic [N-1:0]      core_is_amo_i;
    logic [N*5-1:0]    core_amo_type_i;
    logic [N-1:0]      core_done_o;
    logic [XLEN-1:0]   core_data_o;
    logic [1:0]        amo_id_o;
    logic              amo_strobe_o;
    logic [XLEN-1:0]   amo_addr_o, amo_data_o;
    logic              amo_rw_o, amo_is_amo_o;
    logic [4:0]        amo_type_o;
    logic              amo_done_i;
    logic [XLEN-1:0]   amo_data_i;
`ifdef DMEM_ARB_STATS_EN
    logic [N*32-1:0]   grant_cnt_o;
    logic [31:0]       contention_cnt_o;
`endif

    dmem_core_arbiter #(.N(N), .XLEN(XLEN)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_strobe_i(core_strobe_i), .core_addr_i(core_addr_i),
        .core_rw_i(core_rw_i), .core_data_i(core_data_i),
        .core_is_amo_i(core_is_amo_i), .core_amo_type_i(core_amo_type_i),
        .core_done_o(core_done_o), .core_data_o(core_data_o),
        .amo_id_o(amo_id_o), .amo_strobe_o(amo_strobe_o),
        .amo_addr_o(amo_addr_o), .amo_data_o(amo_data_o),
        .amo_rw_o(amo_rw_o), .amo_is_amo_o(amo_is_amo_o),
        .amo_type_o(amo_type_o), .amo_done_i(amo_done_i),
        .amo_data_i(amo_data_i)
`ifdef DMEM_ARB_STATS_EN
        , .grant_cnt_o(grant_cnt_o), .contention_cnt_o(contention_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model state
    bit [3:0]    m_pend;
    logic [31:0] m_addr [4];
    logic [31:0] m_data [4];
    logic [6:0]  m_ctl [4];
    int          m_rr, m_gid, m_cont;
    bit          m_arb, m_wait;
    int          m_dcnt [4];
    logic [31:0] g_addr, g_data;
    logic [6:0]  g_ctl;

    // Observations
    int          dcnt_obs [4];
    int          strobe_at, last_done_cyc;
    logic [3:0]  last_done_vec;
    logic [31:0] last_done_data;
    int          issued_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_rr = 0; m_gid = 0; m_cont = 0; m_arb = 0; m_wait = 0;
        g_addr = '0; g_data = '0; g_ctl = '0;
        for (int k = 0; k < 4; k++) begin
            m_dcnt[k] = 0; dcnt_obs[k] = 0;
            m_addr[k] = '0; m_data[k] = '0; m_ctl[k] = '0;
        end
    endtask

    task automatic model_edge();
        bit       done, arb;
        bit [3:0] pend0;
        int       w, gid0;
        pend0 = m_pend;
        gid0  = m_gid;
        done  = m_wait && amo_done_i;
        arb   = !m_arb && !m_wait && (m_pend != 0);
        if (!m_arb && !m_wait) begin
            if ($countones(m_pend) >= 2) m_cont++;
        end else if ((m_pend & ~(4'b1 << m_gid)) != 0) m_cont++;
        if (done) begin
            m_pend[gid0] = 1'b0;
            m_rr = (gid0 + 1) % 4;
            m_wait = 1'b0;
            m_dcnt[gid0]++;
        end
        if (m_arb) begin m_arb = 1'b0; m_wait = 1'b1; end
        if (arb) begin
            w = -1;
            for (int i = 0; i < 4; i++)
                if (w < 0 && pend0[(m_rr + i) % 4]) w = (m_rr + i) % 4;
            m_gid = w; g_addr = m_addr[w]; g_data = m_data[w]; g_ctl = m_ctl[w];
            m_arb = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            if (core_strobe_i[k] && (!pend0[k] || (done && gid0 == k))) begin
                m_pend[k] = 1'b1;
                m_addr[k] = core_addr_i[k*32 +: 32];
                m_data[k] = core_data_i[k*32 +: 32];
                m_ctl[k]  = {core_rw_i[k], core_is_amo_i[k], core_amo_type_i[k*5 +: 5]};
            end
        end
    endtask

    // One clock cycle: inputs already driven; check, clock, update model.
    task automatic tick();
        logic [3:0] exp_done;
        #1;
        exp_done = '0;
        if (m_wait && amo_done_i) exp_done[m_gid] = 1'b1;
        chk("strobe", amo_strobe_o, m_arb);
        chk("done_vec", core_done_o, exp_done);
        chk("rdata", core_data_o, amo_data_i);
        if (m_arb || m_wait) begin
            chk("id", amo_id_o, m_gid);
            chk("addr", amo_addr_o, g_addr);
            chk("wdata", amo_data_o, g_data);
            chk("ctl", {amo_rw_o, amo_is_amo_o, amo_type_o}, g_ctl);
        end
        if (amo_strobe_o === 1'b1) begin
            strobe_at = cyc;
            issued_q.push_back(int'(amo_id_o));
        end
        if (core_done_o != 0) begin
            last_done_vec = core_done_o; last_done_data = core_data_o; last_done_cyc = cyc;
            for (int k = 0; k < 4; k++) if (core_done_o[k]) dcnt_obs[k]++;
        end
        @(posedge clk_i);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input bit rw,
                           input logic [31:0] d, input bit amo, input logic [4:0] ty);
        core_strobe_i[k] = 1'b1;
        core_addr_i[k*32 +: 32] = a;
        core_data_i[k*32 +: 32] = d;
        core_rw_i[k] = rw;
        core_is_amo_i[k] = amo;
        core_amo_type_i[k*5 +: 5] = ty;
    endtask

    task automatic run_until_strobe(input int budget, input string tag);
        int n;
        n = 0;
        strobe_at = -1;
        while (strobe_at < 0 && n < budget) begin tick(); n++; end
        if (strobe_at < 0) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        core_strobe_i = '0; amo_done_i = 1'b0; amo_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_outs", {core_done_o, core_data_o, amo_id_o, amo_strobe_o}, 0);
        chk("rst_payload", {amo_addr_o, amo_data_o, amo_rw_o, amo_is_amo_o, amo_type_o}, 0);
        rst_ni = 1'b1;
        model_reset();
    endtask

    initial begin
        int t0, n, d3;
        core_addr_i = '0; core_data_i = '0; core_rw_i = '0;
        core_is_amo_i = '0; core_amo_type_i = '0;
        strobe_at = -1; last_done_cyc = 0; last_done_vec = '0; last_done_data = '0;
        do_reset();

        // Single read from core 1
        t0 = cyc;
        set_req(1, 32'h100, 1'b0, 32'h0, 1'b0, 5'd0);
        tick();
        core_strobe_i = '0;
        run_until_strobe(10, "single");
        chk("single_lat", strobe_at - t0, 2);
        chk("single_id", amo_id_o, 1);
        chk("single_addr", amo_addr_o, 32'h100);
        tick(); tick();
        amo_done_i = 1'b1; amo_data_i = 32'hDEADBEEF;
        tick();
        amo_done_i = 1'b0; amo_data_i = '0;
        chk("single_done_vec", last_done_vec, 4'b0010);
        chk("single_done_data", last_done_data, 32'hDEADBEEF);

        // All four at once from reset; done held high
        do_reset();
        issued_q.delete();
        t0 = cyc;
        for (int k = 0; k < 4; k++) set_req(k, 32'h1000 + k * 16, 1'b1, 32'hA0 + k, 1'b0, 5'd0);
        amo_done_i = 1'b1;
        tick();
        core_strobe_i = '0;
        n = 0;
        while (dcnt_obs[3] + dcnt_obs[2] + dcnt_obs[1] + dcnt_obs[0] < 4 && n < 40) begin
            tick(); n++;
        end
        amo_done_i = 1'b0;
        chk("all4_count", issued_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < issued_q.size()) chk("all4_order", issued_q[i], i);
        for (int k = 0; k < 4; k++) chk("all4_once", dcnt_obs[k], 1);
        chk("all4_bound", (last_done_cyc - t0) <= 14, 1);

        // AMO hold on core 2 while core 0 requests
        set_req(2, 32'h40, 1'b1, 32'h7, 1'b1, 5'b00000);
        tick();
        core_strobe_i = '0;
        run_until_strobe(10, "amo_issue");
        chk("amo_id", amo_id_o, 2);
        set_req(0, 32'h80, 1'b0, 32'h0, 1'b0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            core_strobe_i = '0;
            chk("amo_hold_id", amo_id_o, 2);
            chk("amo_hold_addr", amo_addr_o, 32'h40);
        end
        amo_done_i = 1'b1;
        tick();
        amo_done_i = 1'b0;
        issued_q.delete();
        run_until_strobe(10, "amo_next");
        chk("amo_next_id", amo_id_o, 0);
        amo_done_i = 1'b1;
        tick();
        amo_done_i = 1'b0;

        // Core 3 re-requests on its own done cycle
        d3 = dcnt_obs[3];
        set_req(3, 32'h300, 1'b0, 32'h0, 1'b0, 5'd0);
        tick();
        core_strobe_i = '0;
        run_until_strobe(10, "rereq1");
        chk("rereq1_id", amo_id_o, 3);
        tick();
        amo_done_i = 1'b1;
        set_req(3, 32'h380, 1'b1, 32'h55, 1'b0, 5'd0);
        tick();
        core_strobe_i = '0; amo_done_i = 1'b0;
        run_until_strobe(10, "rereq2");
        chk("rereq2_id", amo_id_o, 3);
        chk("rereq2_addr", amo_addr_o, 32'h380);
        amo_done_i = 1'b1;
        tick();
        amo_done_i = 1'b0;
        repeat (4) tick();
        chk("rereq_dones", dcnt_obs[3] - d3, 2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                core_strobe_i[k] = ($urandom_range(0, 5) == 0);
                core_addr_i[k*32 +: 32] = $urandom;
                core_data_i[k*32 +: 32] = $urandom;
                core_rw_i[k] = $urandom_range(0, 1) == 1;
                core_is_amo_i[k] = $urandom_range(0, 1) == 1;
                core_amo_type_i[k*5 +: 5] = 5'($urandom_range(0, 31));
            end
            amo_done_i = ($urandom_range(0, 2) == 0);
            amo_data_i = $urandom;
            tick();
        end
        core_strobe_i = '0;
        amo_done_i = 1'b1;
        n = 0;
        while ((m_pend != 0 || m_arb || m_wait) && n < 100) begin tick(); n++; end
        amo_done_i = 1'b0; amo_data_i = '0;
        chk("drain_done", n < 100, 1);
        for (int k = 0; k < 4; k++) chk("rand_done_cnt", dcnt_obs[k], m_dcnt[k]);

        // Asynchronous reset in the middle of WAIT
        set_req(1, 32'h500, 1'b0, 32'h0, 1'b0, 5'd0);
        tick();
        core_strobe_i = '0;
        run_until_strobe(10, "rstwait");
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_outs", {core_done_o, core_data_o, amo_id_o, amo_strobe_o}, 0);
        chk("midrst_payload", {amo_addr_o, amo_data_o, amo_rw_o, amo_is_amo_o, amo_type_o}, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();
        amo_done_i = 1'b1;
        repeat (6) tick();
        amo_done_i = 1'b0;
        chk("midrst_no_done", dcnt_obs[1] + dcnt_obs[0] + dcnt_obs[2] + dcnt_obs[3], 0);

`ifdef DMEM_ARB_STATS_EN
        do_reset();
        chk("stats_rst", {grant_cnt_o, contention_cnt_o}, 0);
        for (int r = 0; r < 3; r++) begin
            set_req(0, 32'h10 + r, 1'b0, 32'h0, 1'b0, 5'd0);
            set_req(1, 32'h20 + r, 1'b0, 32'h0, 1'b0, 5'd0);
            tick();
            core_strobe_i = '0;
            amo_done_i = 1'b1;
            n = 0;
            while ((m_pend != 0 || m_arb || m_wait) && n < 20) begin tick(); n++; end
            amo_done_i = 1'b0;
        end
        chk("stats_grant0", grant_cnt_o[31:0], 3);
        chk("stats_grant1", grant_cnt_o[63:32], 3);
        chk("stats_cont_model", contention_cnt_o, m_cont);
        chk("stats_cont_nz", contention_cnt_o > 0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
